// File: rtl/shot_clk_pkg.sv
// Shared types and constants for the shot clock controller.
package shot_clk_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_e;

    localparam logic [4:0] SEC_24 = 5'd24;
    localparam logic [4:0] SEC_30 = 5'd30;

    function automatic logic [4:0] start_value(input logic sel24);
        return sel24 ? SEC_24 : SEC_30;
    endfunction

endpackage

// File: rtl/shot_clk_ctrl_btn_debounce.sv
// Active-low pushbutton conditioner: 2-FF synchronizer, debounce counter and
// one-cycle press pulse on the accepted 1->0 transition.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_n_i,
    output logic press_o
);

    localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    // Counter tracks consecutive cycles the synchronized level disagrees
    // with the accepted level; any agreement restarts it.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
                press_d = ~sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= '1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_n_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/shot_clk_ctrl.sv
// Shot clock run/pause/reload controller: FSM, 1 Hz prescaler, countdown.
// Define SHOT_CLK_BUZZER_EN to build the timed expiry buzzer.
module shot_clk_ctrl
    import shot_clk_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned DEBOUNCE_CYC = 1_000_000,
    parameter int unsigned BUZZ_SEC     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause_n,
    input  logic       reload_n,
    input  logic       sel24,
    output logic [4:0] secs,
    output logic       running,
    output logic       expired,
    output logic       tick,
    output logic       buzzer
);

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [4:0]    secs_q, secs_d;
    logic          running_q, expired_q, tick_q, tick_d;
    logic          pause_ev, reload_ev;
    logic [4:0]    start_val;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_pause_db (
        .clk_i   (clk),
        .rst_i   (rst),
        .btn_n_i (pause_n),
        .press_o (pause_ev)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_reload_db (
        .clk_i   (clk),
        .rst_i   (rst),
        .btn_n_i (reload_n),
        .press_o (reload_ev)
    );

    assign start_val = start_value(sel24);

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        secs_d  = secs_q;
        tick_d  = 1'b0;
        if (reload_ev) begin
            state_d = IDLE;
            secs_d  = start_val;
            pre_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    secs_d = start_val;
                    pre_d  = '0;
                    if (pause_ev) state_d = RUN;
                end
                RUN: begin
                    // The pause cycle itself holds the prescaler, so the
                    // partial second resumes exactly where it stopped.
                    if (pause_ev) begin
                        state_d = PAUSE;
                    end else if (pre_q == PRE_LAST) begin
                        pre_d  = '0;
                        tick_d = 1'b1;
                        if (secs_q <= 5'd1) begin
                            secs_d  = '0;
                            state_d = EXPIRED;
                        end else begin
                            secs_d = secs_q - 1'b1;
                        end
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
                PAUSE: begin
                    if (pause_ev) state_d = RUN;
                end
                EXPIRED: begin
                    secs_d = '0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            secs_q    <= SEC_30;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            secs_q    <= secs_d;
            running_q <= (state_d == RUN);
            expired_q <= (state_d == EXPIRED);
            tick_q    <= tick_d;
        end
    end

    assign secs    = secs_q;
    assign running = running_q;
    assign expired = expired_q;
    assign tick    = tick_q;

`ifdef SHOT_CLK_BUZZER_EN
    localparam int unsigned BUZZ_CYC = BUZZ_SEC * CLK_HZ;
    localparam int unsigned BW = (BUZZ_CYC > 0) ? $clog2(BUZZ_CYC + 1) : 1;

    logic [BW-1:0] buzz_cnt_q, buzz_cnt_d;
    logic          buzzer_q;

    always_comb begin
        buzz_cnt_d = buzz_cnt_q;
        if (reload_ev) begin
            buzz_cnt_d = '0;
        end else if (state_q != EXPIRED && state_d == EXPIRED) begin
            buzz_cnt_d = BW'(BUZZ_CYC);
        end else if (buzz_cnt_q != '0) begin
            buzz_cnt_d = buzz_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buzz_cnt_q <= '0;
            buzzer_q   <= 1'b0;
        end else begin
            buzz_cnt_q <= buzz_cnt_d;
            buzzer_q   <= (buzz_cnt_d != '0);
        end
    end

    assign buzzer = buzzer_q;
`else
    localparam int unsigned buzz_sec_unused = BUZZ_SEC;
    assign buzzer = 1'b0;
`endif

endmodule

// File: tb/tb_shot_clk_ctrl.sv
// Directed bench for shot_clk_ctrl with CLK_HZ=10, DEBOUNCE_CYC=4, BUZZ_SEC=2.
module tb_shot_clk_ctrl;

`ifdef SHOT_CLK_BUZZER_EN
    localparam logic BE = 1'b1;
`else
    localparam logic BE = 1'b0;
`endif

    logic       clk, rst, pause_n, reload_n, sel24;
    logic [4:0] secs;
    logic       running, expired, tick, buzzer;

    int n_vec = 0;
    int n_bad = 0;

    shot_clk_ctrl #(.CLK_HZ(10), .DEBOUNCE_CYC(4), .BUZZ_SEC(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .pause_n  (pause_n),
        .reload_n (reload_n),
        .sel24    (sel24),
        .secs     (secs),
        .running  (running),
        .expired  (expired),
        .tick     (tick),
        .buzzer   (buzzer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pause_n;
        logic        reload_n;
        logic        sel24;
        int unsigned cyc;
        logic [4:0]  secs;
        logic        running;
        logic        expired;
        logic        tick;
        logic        buzzer;
    } vec_t;

    vec_t vecs[14];

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [4:0] es, input logic er,
                         input logic ee, input logic et, input logic eb);
        n_vec++;
        if ({secs, running, expired, tick, buzzer} !== {es, er, ee, et, eb}) begin
            n_bad++;
            $display("FAIL %s @%0t: got secs=%0d run=%b exp=%b tick=%b buz=%b, want secs=%0d run=%b exp=%b tick=%b buz=%b",
                     name, $time, secs, running, expired, tick, buzzer, es, er, ee, et, eb);
        end
    endtask

    task automatic press_pause();
        pause_n = 1'b0;
        step(7);
        pause_n = 1'b1;
    endtask

    task automatic press_reload();
        reload_n = 1'b0;
        step(7);
        reload_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //         pn    rn    s24  cyc secs  run   exp   tick  buz
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 0, 5'd30, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1, 5'd24, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1, 5'd30, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1, 5'd24, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 6, 5'd24, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1, 5'd24, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 9, 5'd24, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1, 5'd23, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1, 5'd23, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 5, 5'd23, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 6, 5'd22, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1, 5'd30, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1, 5'd24, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 8, 5'd24, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b0; pause_n = 1'b1; reload_n = 1'b1; sel24 = 1'b1;
        #1 rst = 1'b1;
        #1 check("reset_async", 5'd30, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3 rst = 1'b0;

        // Reset follow-up, IDLE sel24 tracking, first decrement, sel24 ignored, reload
        for (int i = 0; i < 14; i++) begin
            pause_n  = vecs[i].pause_n;
            reload_n = vecs[i].reload_n;
            sel24    = vecs[i].sel24;
            step(vecs[i].cyc);
            check($sformatf("vec%0d", i), vecs[i].secs, vecs[i].running,
                  vecs[i].expired, vecs[i].tick, vecs[i].buzzer);
        end

        // Bouncing pause button: only the final stable low is accepted
        for (int b = 0; b < 5; b++) begin
            pause_n = 1'b0; step(2);
            pause_n = 1'b1; step(2);
        end
        check("bounce_idle", 5'd24, 1'b0, 1'b0, 1'b0, 1'b0);
        pause_n = 1'b0;
        step(6);
        check("bounce_lat6", 5'd24, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1);
        check("bounce_run", 5'd24, 1'b1, 1'b0, 1'b0, 1'b0);
        step(11);
        check("bounce_once", 5'd23, 1'b1, 1'b0, 1'b0, 1'b0);
        pause_n = 1'b1;
        press_reload();
        check("bounce_reload", 5'd24, 1'b0, 1'b0, 1'b0, 1'b0);
        step(8);

        // Full countdown from 24 to expiry
        press_pause();
        check("cd_start", 5'd24, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 24; k++) begin
            step(9);
            check($sformatf("cd_hold%0d", k), 5'(25 - k), 1'b1, 1'b0, 1'b0, 1'b0);
            step(1);
            check($sformatf("cd_tick%0d", k), 5'(24 - k), (k < 24), (k == 24), 1'b1,
                  (k == 24) && BE);
        end
        press_pause();
        check("exp_pause_ign", 5'd0, 1'b0, 1'b1, 1'b0, BE);
        step(12);
        check("buzz_last", 5'd0, 1'b0, 1'b1, 1'b0, BE);
        step(1);
        check("buzz_off", 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        press_reload();
        check("exp_reload", 5'd24, 1'b0, 1'b0, 1'b0, 1'b0);
        step(8);

        // Pause mid-second preserves the prescaler
        press_pause();
        step(8);
        press_pause();
        check("paused", 5'd23, 1'b0, 1'b0, 1'b0, 1'b0);
        step(50);
        check("paused_hold", 5'd23, 1'b0, 1'b0, 1'b0, 1'b0);
        press_pause();
        check("resumed", 5'd23, 1'b1, 1'b0, 1'b0, 1'b0);
        step(5);
        check("resume_pre", 5'd23, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1);
        check("resume_tick", 5'd22, 1'b1, 1'b0, 1'b1, 1'b0);

        // Reload and pause together, landing on a terminal-count cycle at secs=17
        step(53);
        check("at17", 5'd17, 1'b1, 1'b0, 1'b0, 1'b0);
        pause_n = 1'b0; reload_n = 1'b0;
        step(6);
        check("both_ev", 5'd17, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1);
        check("both_idle", 5'd24, 1'b0, 1'b0, 1'b0, 1'b0);
        pause_n = 1'b1; reload_n = 1'b1;
        step(8);
        check("both_stay", 5'd24, 1'b0, 1'b0, 1'b0, 1'b0);

        // Second expiry, reload while the buzzer sounds
        press_pause();
        check("cd2_start", 5'd24, 1'b1, 1'b0, 1'b0, 1'b0);
        step(240);
        check("cd2_exp", 5'd0, 1'b0, 1'b1, 1'b1, BE);
        reload_n = 1'b0;
        step(6);
        check("cd2_pre_rl", 5'd0, 1'b0, 1'b1, 1'b0, BE);
        step(1);
        check("cd2_reload", 5'd24, 1'b0, 1'b0, 1'b0, 1'b0);
        reload_n = 1'b1;
        step(8);

        // Asynchronous reset mid-run
        press_pause();
        step(3);
        #3 rst = 1'b1;
        #1 check("rst_async_mid", 5'd30, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2);
        check("rst_held", 5'd30, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step(1);
        check("rst_release", 5'd24, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/shot_clk_ctrl.md
# shot_clk_ctrl

Run/pause/reload controller for the basketball shot clock. It conditions the two raw pushbuttons and owns the 1 Hz prescaler and the countdown register. It sequences the countdown through a four-state machine and drives the expiry buzzer. The `secs` output feeds the downstream digit-split and seven-segment decode logic unchanged.

## Interface
- `CLK_HZ`, 50_000_000: clock cycles per second (prescaler terminal count + 1)
- `DEBOUNCE_CYC`, 1_000_000: cycles a synchronized button level must hold before it is accepted (20 ms)
- `BUZZ_SEC`, 2: buzzer duration in seconds
- `clk` in 1: sole clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `pause_n` in 1: raw pushbuttons, active-low; each press toggles run/pause
- `reload_n` in 1: raw pushbuttons, active-low; each press reloads the start value
- `sel24` in 1: start-value switch; 1 → 24 s, 0 → 30 s
- `secs` out 5: seconds remaining, 0..30
- `running` out 1: high in RUN
- `expired` out 1: high in EXPIRED
- `tick` out 1: one-cycle pulse on each decrement
- `buzzer` out 1: buzzer drive

## Operation
- **Button conditioning (per button)**
  - 2-FF synchronizer, then debounce counter.
  - The debounced level updates only after the synchronized level has differed from it for `DEBOUNCE_CYC` consecutive cycles. Any bounce restarts the count.
  - Press event is a one-cycle pulse when the debounced level goes 1→0. Release produces no event.
- **States:** IDLE, RUN, PAUSE, EXPIRED. Reset enters IDLE.
- **IDLE**
  - `secs` tracks the start value every cycle: `sel24` is live.
  - Prescaler is held at 0.
  - Pause event → RUN.
- **RUN**
  - Prescaler increments 0..`CLK_HZ`-1.
  - At `CLK_HZ`-1: `tick`=1 that cycle, prescaler wraps to 0, and `secs` decrements on the same edge.
  - If `secs`==1 at that tick, `secs` becomes 0 and the state becomes EXPIRED.
  - Pause event → PAUSE.
- **PAUSE**
  - Prescaler and `secs` both hold; the partial second is preserved.
  - Pause event → RUN, and counting resumes from the held prescaler value.
- **EXPIRED**
  - `secs`=0 and is held there.
  - Pause events are ignored.
- **Reload event, any state:** → IDLE, `secs` ← start value, prescaler ← 0, buzzer off.
- **Reload and pause events in the same cycle:** reload wins, the pause event is dropped, and the result is IDLE.
- **Reload during a terminal-count cycle in RUN:** reload wins. No decrement and no `tick`.
- **`sel24` outside IDLE:** ignored. Changing the switch mid-run has no effect until the next reload.
- **Arithmetic:** `secs` is 5-bit unsigned and never decrements below 0. The prescaler width is $clog2(CLK_HZ).

## Timing
- **Reset values:**
  - `secs`=30, `running`=0, `expired`=0, `tick`=0, `buzzer`=0
  - prescaler 0, debounced levels 1, debounce counters 0
  - The first cycle after reset, `secs` follows `sel24`.
- **Press latency:** a clean raw press edge produces its event `DEBOUNCE_CYC`+2 cycles later. The state changes on the next edge.
- **All outputs are registered.**
  - `running` and `expired` reflect the current state.
  - `tick` is a registered pulse aligned with the cycle in which `secs` shows the new value.
- **First decrement:** `CLK_HZ` cycles after entering RUN from IDLE.
- **Reset mid-operation:** asserting `rst` forces all reset values immediately, independent of `clk`.

## Configuration
- **`SHOT_CLK_BUZZER_EN` defined:**
  - A buzzer timer loads `BUZZ_SEC`*`CLK_HZ` on entry to EXPIRED.
  - `buzzer`=1 while the timer is nonzero, then 0 while the state remains EXPIRED.
  - Reload clears the timer and `buzzer` immediately.
- **Not defined:** no timer logic; `buzzer` is tied 0. All other behaviour is identical.

## Structure
- **Shared package `shot_clk_pkg`:**
  - state enum {IDLE, RUN, PAUSE, EXPIRED}
  - constants `SEC_24`=5'd24 and `SEC_30`=5'd30
- **Sub-module `btn_debounce`:** synchronizer, debounce counter and press-event pulse, parameterized by `DEBOUNCE_CYC`. Instantiated twice, once per button.
- **Top level:** contains the FSM, prescaler, countdown and buzzer timer.

## Test plan
All scenarios use `CLK_HZ`=10, `DEBOUNCE_CYC`=4, `BUZZ_SEC`=2.

- **Reset:** `rst` pulse with `sel24`=1 → `secs` 30, then 24 the next cycle; state IDLE, all flags 0. Toggle `sel24` to 0 → `secs`=30.
- **Debounce:** `pause_n` bounces 0/1 every 2 cycles for 20 cycles, then held low → exactly one event, 6 cycles after the final stable edge; `running`=1 on the next edge.
- **Countdown to expiry:** `sel24`=1, press pause → `tick` every 10 cycles; `secs` goes 24→0 after 240 cycles; `expired`=1; `buzzer` high for 20 cycles. Further pause presses are ignored.
- **Pause mid-second:** press pause 4 cycles after a tick, hold 50 cycles, then press again → next tick arrives 6 RUN cycles after resume; `secs` unchanged while paused.
- **Simultaneous events:** reload and pause events in the same cycle while in RUN with `secs`=17 → IDLE, `secs`=start, no `tick`, `running`=0.
- **Reload from EXPIRED:** with `SHOT_CLK_BUZZER_EN`, reload during buzzer → `buzzer` 0 on the next edge, `secs`=24, state IDLE. Build without the macro → `buzzer` never asserts.
